// File: rtl/pipelined_adder_tree_32.sv
// Five-stage pipelined reduction of 32 signed 8-bit lanes plus a 16-bit carry-in operand.
// Result wraps modulo 2^DIM_WIDTH; one vector accepted and one result produced every clock.
module pipelined_adder_tree_32 #(
  parameter int unsigned INPUT_NUM   = 32,
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned DIM_WIDTH   = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [INPUT_NUM-1:0][INPUT_WIDTH-1:0]  inputs,
  input  logic [DIM_WIDTH-1:0]                   last_in,
  output logic [DIM_WIDTH-1:0]                   out
);

  localparam int unsigned N1 = INPUT_NUM / 2;
  localparam int unsigned N2 = N1 / 2;
  localparam int unsigned N3 = N2 / 2;
  localparam int unsigned N4 = N3 / 2;

  localparam int unsigned W1 = INPUT_WIDTH + 1;
  localparam int unsigned W2 = INPUT_WIDTH + 2;
  localparam int unsigned W3 = INPUT_WIDTH + 3;
  localparam int unsigned W4 = INPUT_WIDTH + 4;
  localparam int unsigned W5 = INPUT_WIDTH + 5;

  // last_in must wait out the four tree levels before meeting the tree sum
  localparam int unsigned LastDelay = 4;

  logic [W1-1:0]        l1_d [N1];
  logic [W1-1:0]        l1_q [N1];
  logic [W2-1:0]        l2_d [N2];
  logic [W2-1:0]        l2_q [N2];
  logic [W3-1:0]        l3_d [N3];
  logic [W3-1:0]        l3_q [N3];
  logic [W4-1:0]        l4_d [N4];
  logic [W4-1:0]        l4_q [N4];
  logic [DIM_WIDTH-1:0] ld_d [LastDelay];
  logic [DIM_WIDTH-1:0] ld_q [LastDelay];
  logic [W5-1:0]        tree_sum;
  logic [DIM_WIDTH-1:0] out_d;
  logic [DIM_WIDTH-1:0] out_q;

  // Every level sign-extends both operands by one bit so the pairwise sum cannot overflow.
  always_comb begin
    for (int k = 0; k < N1; k++) begin
      l1_d[k] = {inputs[2*k][INPUT_WIDTH-1], inputs[2*k]}
              + {inputs[2*k+1][INPUT_WIDTH-1], inputs[2*k+1]};
    end
    for (int k = 0; k < N2; k++) begin
      l2_d[k] = {l1_q[2*k][W1-1], l1_q[2*k]} + {l1_q[2*k+1][W1-1], l1_q[2*k+1]};
    end
    for (int k = 0; k < N3; k++) begin
      l3_d[k] = {l2_q[2*k][W2-1], l2_q[2*k]} + {l2_q[2*k+1][W2-1], l2_q[2*k+1]};
    end
    for (int k = 0; k < N4; k++) begin
      l4_d[k] = {l3_q[2*k][W3-1], l3_q[2*k]} + {l3_q[2*k+1][W3-1], l3_q[2*k+1]};
    end
    ld_d[0] = last_in;
    for (int k = 1; k < LastDelay; k++) begin
      ld_d[k] = ld_q[k-1];
    end
    tree_sum = {l4_q[0][W4-1], l4_q[0]} + {l4_q[1][W4-1], l4_q[1]};
    out_d    = {{(DIM_WIDTH-W5){tree_sum[W5-1]}}, tree_sum} + ld_q[LastDelay-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l1_q  <= '{default: '0};
      l2_q  <= '{default: '0};
      l3_q  <= '{default: '0};
      l4_q  <= '{default: '0};
      ld_q  <= '{default: '0};
      out_q <= '0;
    end else begin
      l1_q  <= l1_d;
      l2_q  <= l2_d;
      l3_q  <= l3_d;
      l4_q  <= l4_d;
      ld_q  <= ld_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pipelined_adder_tree_32.sv
// Directed bench for pipelined_adder_tree_32: latency, sign extension, wrap, streaming, reset.
module tb_pipelined_adder_tree_32;

  logic             clk;
  logic             reset;
  logic [31:0][7:0] inputs_s;
  logic [15:0]      last_in_s;
  logic [15:0]      out_s;

  int n_assert;
  int n_fail;

  pipelined_adder_tree_32 dut (
    .clk     (clk),
    .reset   (reset),
    .inputs  (inputs_s),
    .last_in (last_in_s),
    .out     (out_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] exp);
    n_assert++;
    assert (out_s === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, out_s, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [7:0] v, input logic [15:0] li);
    for (int i = 0; i < 32; i++) inputs_s[i] = v;
    last_in_s = li;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 32; i++) inputs_s[i] = 8'(i);
    last_in_s = 16'd3;
  endtask

  task automatic set_mixed();
    for (int i = 0; i < 32; i++) inputs_s[i] = (i < 16) ? 8'hF6 : 8'h0A;
    last_in_s = 16'd3;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    set_ramp();
    #2;
    check("reset_initial", 16'h0000);

    // Ramp: 0+1+..+31 = 496, +3 = 499
    @(negedge clk);
    reset = 1'b1;
    step(4);
    check("ramp_not_yet", 16'h0000);
    step(1);
    check("ramp", 16'd499);

    @(negedge clk);
    set_all(8'd10, 16'd3);
    step(5);
    check("uniform", 16'd323);

    @(negedge clk);
    set_mixed();
    step(5);
    check("mixed_sign", 16'd3);

    @(negedge clk);
    set_all(8'h80, 16'h0000);
    step(5);
    check("all_min", 16'hF000);

    @(negedge clk);
    set_all(8'h01, 16'hFFFF);
    step(5);
    check("wrap", 16'h001F);

    // Back-to-back vectors on consecutive edges
    @(negedge clk);
    set_ramp();
    @(negedge clk);
    set_all(8'd10, 16'd3);
    @(negedge clk);
    set_mixed();
    step(2);
    check("stream_hold", 16'h001F);
    step(1);
    check("stream_0", 16'd499);
    step(1);
    check("stream_1", 16'd323);
    step(1);
    check("stream_2", 16'd3);

    // Asynchronous reset mid-stream, between edges
    @(negedge clk);
    set_ramp();
    step(5);
    check("pre_reset", 16'd499);
    @(negedge clk);
    set_all(8'd10, 16'd3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("reset_async", 16'h0000);
    step(2);
    check("reset_held", 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    step(1);
    check("post_reset_e1", 16'h0000);
    step(3);
    check("post_reset_e4", 16'h0000);
    step(1);
    check("post_reset_vec", 16'd323);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_tree_32.md
# pipelined_adder_tree_32

Fully pipelined 32-input signed reduction tree that sums 32 signed 8-bit operands together with one 16-bit carry-in operand (`last_in`) and produces a 16-bit wrapped result. It is the accumulation back end of the hyperdimensional encoder. Upstream, one `mux_two_one` per lane selects either `feature` or `-feature` (8-bit two's complement) according to that lane's projection bit. `last_in` carries the previous partial result, so long dimensions can be accumulated across passes. The block accepts a new operand vector every clock.

## Interface
Parameters:
- INPUT_NUM, 32, number of lanes (fixed at 32; the tree depth of 5 assumes it)
- INPUT_WIDTH, 8, lane width, signed two's complement
- DIM_WIDTH, 16, width of `last_in` and `out`

Ports:
- clk  input  1  single clock; all registers update on its rising edge
- reset  input  1  asynchronous, active-low; while low, all pipeline registers and `out` are forced to 0
- inputs  input  [INPUT_NUM-1:0][INPUT_WIDTH-1:0]  32 signed 8-bit lane values (already polarity-selected upstream)
- last_in  input  DIM_WIDTH  16-bit carry-in operand, sampled in the same cycle as `inputs`
- out  output  DIM_WIDTH  registered sum, wrapped modulo 2^16

Companion primitive `mux_two_one`: `out = sel ? in1 : in0`, purely combinational, 8-bit data. Upstream it is wired with `in1 = feature` and `in0 = -feature`.

## Operation
- Each lane is interpreted as signed 8-bit and sign-extended before addition.
- Level 1 forms 16 pairwise sums (9-bit). Level 2 forms 8 sums (10-bit), level 3 forms 4 (11-bit), level 4 forms 2 (12-bit).
- Level 5 adds the last two sums plus the delayed `last_in`. This addition is in 16 bits, with the 13-bit tree sum sign-extended, and the result is truncated to 16 bits (wrap-around, no saturation, no overflow flag).
- `last_in` travels through a 16-bit delay line alongside the tree, so it is always added to the lane vector sampled in the same cycle.
- Result: out = (sum over i of sext(inputs[i]) + last_in) mod 2^16.
- Tree sum range is −4096..+4064, which never overflows internally; only the final add with `last_in` can wrap.
- Lane order does not matter; pairing is (2k, 2k+1) at each level.
- No handshake, valid, or enable: every cycle is a transfer. Consumers count cycles themselves.

## Timing
- Each tree level is followed by a register, so there are 5 register stages. Level 5 is the `out` register.
- Latency: the vector sampled at rising edge N appears on `out` immediately after rising edge N+4. That is 5 clock edges including the sampling edge, i.e. `out` is valid 5 cycles after the inputs are presented.
- Throughput: one result per cycle; back-to-back vectors produce back-to-back results.
- Reset asserted (low) clears all stages and `out` to 0 at once, without waiting for a clock edge.
- After reset deasserts, `out` stays 0 until the first post-reset vector reaches the output. Those 0s come from the cleared pipeline, not from summation.
- Reset asserted mid-stream discards every in-flight vector. Outputs resume with the first vector sampled after release.
- `inputs` and `last_in` must be stable around the sampling edge. There are no combinational paths from input to output.

## Test plan
- Ramp: lane i = i (0..31), `last_in` = 3, held steady → `out` = 499 (0x01F3), 5 cycles after application.
- Uniform: all lanes = 10, `last_in` = 3 → `out` = 323.
- Mixed polarity: lanes 0–15 = −10 (0xF6), lanes 16–31 = +10, `last_in` = 3 → `out` = 3. This proves sign extension.
- Extremes and wrap:
  - all lanes = −128, `last_in` = 0 → `out` = 0xF000
  - all lanes = 1, `last_in` = 0xFFFF → `out` = 0x001F (wraps)
- Pipelining: apply the ramp, uniform, and mixed vectors on consecutive cycles → `out` = 499, 323, 3 on consecutive cycles with 5-cycle latency.
- Reset: pull reset low mid-stream between clock edges → `out` = 0 immediately. After release, `out` stays 0 until the first new vector emerges with correct latency.
